cjg_stack_spill: RTL
====================

// Module: cjg_stack_spill
// PURPOSE
//  Memory-backed hardware call/data stack for the core: DEPTH on-chip entries plus a spill region in data memory.
//  Core side uses the same push/pop/d/q contract as the on-chip stack. Memory side is a req/ack word master.
//  Push on a full on-chip buffer spills the oldest entry to memory. An empty on-chip buffer with spilled entries refills automatically.
// PARAMETERS
//  WIDTH      32    data word width (core and memory)
//  DEPTH      16    on-chip entries (power of 2, >=2)
//  ADDR_WIDTH 32    memory word-address width
//  MEM_DEPTH  256   max spilled entries in memory
//  BASE_ADDR  0     word address of spill slot 0
// PORTS
//  clk       in  1          clock
//  reset     in  1          async active-low reset
//  d         in  WIDTH      push data
//  push      in  1          push request (held until accepted)
//  pop       in  1          pop request (held until accepted)
//  q         out WIDTH      top of stack; 0 when on-chip count==0
//  stall     out 1          request not accepted this cycle
//  empty     out 1          on-chip count==0 && spill_cnt==0
//  mem_req   out 1          memory request
//  mem_we    out 1          1=write (spill), 0=read (fill)
//  mem_addr  out ADDR_WIDTH word address
//  mem_wdata out WIDTH      spill data
//  mem_rdata in  WIDTH      fill data, valid with mem_ack
//  mem_ack   in  1          memory completes request
//  scan_in0, scan_en, test_mode in 1; scan_out0 out 1 -- scan hooks, scan_out0 driven 0 in RTL
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE, count=0, spill_cnt=0, all entries 0; q=0, stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
//   Reset mid-transaction abandons it; mem_req drops immediately.
//  On-chip storage: circular buffer, top pointer + count (0..DEPTH). No shifting.
//  FSM IDLE/SPILL/FILL:
//   IDLE, push, count<DEPTH: write d at top+1, count++; stall=0; visible on q next cycle.
//   IDLE, pop, count>0: count--; stall=0.
//   IDLE, push, count==DEPTH, spill_cnt<MEM_DEPTH: stall=1 (combinational); -> SPILL.
//   SPILL: mem_req=1, mem_we=1, mem_addr=BASE_ADDR+spill_cnt, mem_wdata=bottom entry.
//    Outputs are held stable until mem_ack. On ack: spill_cnt++, count--, -> IDLE. The held push is then accepted in IDLE.
//   IDLE, count==0, spill_cnt>0: -> FILL, regardless of requests.
//   FILL: mem_req=1, mem_we=0, mem_addr=BASE_ADDR+spill_cnt-1. On ack: mem_rdata becomes top, count=1, spill_cnt--, -> IDLE.
//   stall=1 whenever state!=IDLE and push|pop.
//   mem_req deasserts the cycle after ack; no back-to-back requests.
//  push&pop together: push wins, pop ignored, matching the on-chip stack.
//  Pop with empty==1: ignored, no state change.
//  Push with count==DEPTH and spill_cnt==MEM_DEPTH: dropped, stall=0.
//  Address arithmetic: modulo 2^ADDR_WIDTH; spill_cnt width clog2(MEM_DEPTH+1).
// CONFIGURATION
//  CJG_STACK_ERR_EN defined: adds output err (1 bit, reset 0).
//   err goes sticky high on a dropped push (overflow) or an ignored empty pop (underflow). Only reset clears it.
//  Not defined: no err port; overflow and underflow are silently ignored as above.
// STRUCTURE
//  cjg_stack_pkg: state enum (IDLE/SPILL/FILL) and a clog2 function.
//  Sub-module cjg_stack_rf: DEPTH x WIDTH circular register file.
//   Top/bottom read ports, one write port, async-reset entries.
//   FSM, counters and memory master stay in cjg_stack_spill.
// TESTING
//  1. Push 0x11,0x22,0x33 then pop x3 (DEPTH=16) -> q=0x33,0x22,0x11, then 0; stall never 1; mem_req never 1.
//  2. Push 17 values 1..17 -> 17th push stalls.
//     Spill write addr BASE_ADDR+0, data 1; after ack, q=17, count=16, spill_cnt=1.
//  3. From test 2, pop 16 times -> FILL read at BASE_ADDR+0; mem_rdata=1 gives q=1, empty=0. One more pop -> empty=1.
//  4. Delay mem_ack 5 cycles during SPILL -> mem_req/mem_addr/mem_wdata stable for 5 cycles. Push held, stall=1 throughout.
//  5. push=pop=1 with d=0xAA on stack [0x55] -> q=0xAA, count=2.
//     Pop when empty -> no change; err=1 if CJG_STACK_ERR_EN.
//  6. Assert reset during FILL with mem_req=1 -> mem_req=0, q=0, empty=1 immediately; late mem_ack ignored.

Source files
------------

// File: rtl/cjg_stack_pkg.sv
// Shared types and helpers for the memory-backed call/data stack.
package cjg_stack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPILL = 2'd1,
        FILL  = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/cjg_stack_rf.sv
// DEPTH x WIDTH circular register file: one write port, top and bottom read ports.
module cjg_stack_rf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    top_addr,
    output logic [WIDTH-1:0] top_data,
    input  logic [PW-1:0]    bot_addr,
    output logic [WIDTH-1:0] bot_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign top_data = mem[top_addr];
    assign bot_data = mem[bot_addr];

endmodule

// File: rtl/cjg_stack_spill.sv
// Hardware stack with DEPTH on-chip entries that spills/refills through a memory word master.
// Define CJG_STACK_ERR_EN to add a sticky err output for overflow/underflow.
module cjg_stack_spill
    import cjg_stack_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          DEPTH      = 16,
    parameter int          ADDR_WIDTH = 32,
    parameter int          MEM_DEPTH  = 256,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      d,
    input  logic                  push,
    input  logic                  pop,
    output logic [WIDTH-1:0]      q,
    output logic                  stall,
    output logic                  empty,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ack,
    input  logic                  scan_in0,
    input  logic                  scan_en,
    input  logic                  test_mode,
`ifdef CJG_STACK_ERR_EN
    output logic                  err,
`endif
    output logic                  scan_out0
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);
    localparam int SW = clog2(MEM_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    state_e          state, state_n;
    logic [PW-1:0]   top, top_n, wptr, bot_idx;
    logic [CW-1:0]   count, cnt_n;
    logic [SW-1:0]   spill_cnt, sc_n;
    logic            rf_we, ovf, unf;
    logic [WIDTH-1:0] rf_wdata, top_data, bot_data;
    logic [ADDR_WIDTH-1:0] spill_ext;

    assign wptr      = top + PW'(1);
    // Oldest entry sits count-1 slots below top; wraps naturally when count==DEPTH.
    assign bot_idx   = top - PW'(count) + PW'(1);
    assign rf_wdata  = (state == FILL) ? mem_rdata : d;
    assign spill_ext = ADDR_WIDTH'(spill_cnt);

    cjg_stack_rf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_we),
        .waddr    (wptr),
        .wdata    (rf_wdata),
        .top_addr (top),
        .top_data (top_data),
        .bot_addr (bot_idx),
        .bot_data (bot_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            top       <= '0;
            count     <= '0;
            spill_cnt <= '0;
        end else begin
            state     <= state_n;
            top       <= top_n;
            count     <= cnt_n;
            spill_cnt <= sc_n;
        end
    end

    always_comb begin
        state_n = state;
        top_n   = top;
        cnt_n   = count;
        sc_n    = spill_cnt;
        stall   = 1'b0;
        rf_we   = 1'b0;
        ovf     = 1'b0;
        unf     = 1'b0;
        case (state)
            IDLE: begin
                // Refill takes priority; any request waits for it.
                if (count == '0 && spill_cnt != '0) begin
                    state_n = FILL;
                    stall   = push | pop;
                end else if (push) begin
                    if (count != CW'(DEPTH)) begin
                        rf_we = 1'b1;
                        top_n = wptr;
                        cnt_n = count + CW'(1);
                    end else if (spill_cnt != SW'(MEM_DEPTH)) begin
                        stall   = 1'b1;
                        state_n = SPILL;
                    end else begin
                        ovf = 1'b1;
                    end
                end else if (pop) begin
                    if (count != '0) begin
                        cnt_n = count - CW'(1);
                        top_n = top - PW'(1);
                    end else begin
                        unf = 1'b1;
                    end
                end
            end
            SPILL: begin
                stall = push | pop;
                if (mem_ack) begin
                    sc_n    = spill_cnt + SW'(1);
                    cnt_n   = count - CW'(1);
                    state_n = IDLE;
                end
            end
            FILL: begin
                stall = push | pop;
                if (mem_ack) begin
                    rf_we   = 1'b1;
                    top_n   = wptr;
                    cnt_n   = CW'(1);
                    sc_n    = spill_cnt - SW'(1);
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Memory outputs derive from registered state only, so they hold until ack.
    assign mem_req   = (state != IDLE);
    assign mem_we    = (state == SPILL);
    assign mem_wdata = (state == SPILL) ? bot_data : '0;
    always_comb begin
        mem_addr = '0;
        if (state == SPILL)     mem_addr = BASE + spill_ext;
        else if (state == FILL) mem_addr = BASE + spill_ext - ADDR_WIDTH'(1);
    end

    assign q         = (count == '0) ? '0 : top_data;
    assign empty     = (count == '0) && (spill_cnt == '0);
    assign scan_out0 = 1'b0;

`ifdef CJG_STACK_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          err <= 1'b0;
        else if (ovf | unf)  err <= 1'b1;
    end
    logic unused_scan;
    assign unused_scan = scan_in0 | scan_en | test_mode;
`else
    logic unused_scan;
    assign unused_scan = scan_in0 | scan_en | test_mode | ovf | unf;
`endif

endmodule
